// File: rtl/blake2s_hash_ser_pkg.sv
// Shared BLAKE2s digest-serializer constants: digest width, beat width,
// beats per digest and the beat-counter width derived from them.
package blake2s_hash_ser_pkg;

  localparam int HASH_W = 256;
  localparam int BYTE_W = 8;
  localparam int NBYTES = HASH_W / BYTE_W;
  localparam int CNT_W  = $clog2(NBYTES);

endpackage

// File: rtl/blake2s_hash_ser.sv
// BLAKE2s digest serializer: captures a digest on hash_v_i and streams it
// one byte per accepted beat over a valid/ready interface. A digest that
// arrives mid-stream is dropped and flagged on the sticky ovf_o, except on
// the final-beat accept cycle, where it chains on with no bubble.
// Build option: BLAKE2S_SER_LSB_FIRST_EN emits the digest low byte first.
module blake2s_hash_ser
  import blake2s_hash_ser_pkg::*;
#(
  parameter int HASH_W = blake2s_hash_ser_pkg::HASH_W,
  parameter int BYTE_W = blake2s_hash_ser_pkg::BYTE_W
) (
  input  logic              clk,
  input  logic              nreset,
  input  logic              hash_v_i,
  input  logic [HASH_W-1:0] hash_i,
  input  logic              ready_i,
  input  logic              clr_ovf_i,
  output logic              data_v_o,
  output logic [BYTE_W-1:0] data_o,
  output logic              last_o,
  output logic              busy_o,
  output logic              ovf_o
);

  localparam int NB = HASH_W / BYTE_W;
  localparam int CW = $clog2(NB);
  localparam logic [CW-1:0] LAST_CNT = CW'(NB - 1);

  typedef enum logic {IDLE, SEND} state_e;

  state_e            state_q, state_d;
  logic [HASH_W-1:0] sr_q, sr_d, sr_shift;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic              ovf_q, ovf_d;
  logic [BYTE_W-1:0] head;
  logic              send, accept, fin, drop;

`ifdef BLAKE2S_SER_LSB_FIRST_EN
  assign head     = sr_q[BYTE_W-1:0];
  assign sr_shift = sr_q >> BYTE_W;
`else
  assign head     = sr_q[HASH_W-1 -: BYTE_W];
  assign sr_shift = sr_q << BYTE_W;
`endif

  assign send   = (state_q == SEND);
  assign accept = send && ready_i;
  assign fin    = accept && (cnt_q == LAST_CNT);
  // A digest landing on the final-beat accept is chained, not dropped.
  assign drop   = send && hash_v_i && !fin;

  // Next-state, datapath update and outputs.
  always_comb begin
    state_d  = state_q;
    sr_d     = sr_q;
    cnt_d    = cnt_q;
    ovf_d    = ovf_q;
    data_v_o = 1'b0;
    data_o   = '0;
    last_o   = 1'b0;
    case (state_q)
      IDLE: begin
        if (hash_v_i) begin
          sr_d    = hash_i;
          cnt_d   = '0;
          state_d = SEND;
        end
      end
      SEND: begin
        data_v_o = 1'b1;
        data_o   = head;
        last_o   = (cnt_q == LAST_CNT);
        if (fin) begin
          cnt_d = '0;
          if (hash_v_i) begin
            sr_d = hash_i;
          end else begin
            sr_d    = sr_shift;
            state_d = IDLE;
          end
        end else if (accept) begin
          sr_d  = sr_shift;
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
    // Set wins over clear.
    if (drop)           ovf_d = 1'b1;
    else if (clr_ovf_i) ovf_d = 1'b0;
  end

  // State, shift register, beat counter and sticky overflow.
  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      state_q <= IDLE;
      sr_q    <= '0;
      cnt_q   <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      sr_q    <= sr_d;
      cnt_q   <= cnt_d;
      ovf_q   <= ovf_d;
    end
  end

  assign busy_o = send;
  assign ovf_o  = ovf_q;

endmodule

// File: tb/tb_blake2s_hash_ser.sv
// Bench for blake2s_hash_ser: directed scenarios with random ready, random
// digests and random junk on hash_i, checked against a byte-queue model.
module tb_blake2s_hash_ser;

  localparam int N = 32;

  logic         clk = 1'b0;
  logic         nreset = 1'b0;
  logic         hash_v_i = 1'b0;
  logic [255:0] hash_i = '0;
  logic         ready_i = 1'b0;
  logic         clr_ovf_i = 1'b0;
  logic         data_v_o, last_o, busy_o, ovf_o;
  logic [7:0]   data_o;

  int n_chk = 0;
  int n_fail = 0;
  bit ovf_exp = 1'b0;
  logic [7:0] exp_q[$];

  blake2s_hash_ser dut (
    .clk(clk), .nreset(nreset), .hash_v_i(hash_v_i), .hash_i(hash_i),
    .ready_i(ready_i), .clr_ovf_i(clr_ovf_i), .data_v_o(data_v_o),
    .data_o(data_o), .last_o(last_o), .busy_o(busy_o), .ovf_o(ovf_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [255:0] rnd256();
    logic [255:0] r;
    for (int i = 0; i < 8; i++) r[32*i +: 32] = $urandom();
    return r;
  endfunction

  // Wire order of a digest: big-endian bytes, or little-endian in the LSB build.
  task automatic add_digest(input logic [255:0] d);
    for (int k = 0; k < N; k++) begin
`ifdef BLAKE2S_SER_LSB_FIRST_EN
      exp_q.push_back(d[8*k +: 8]);
`else
      exp_q.push_back(d[255 - 8*k -: 8]);
`endif
    end
  endtask

  task automatic check_quiet(input string tag);
    chk({tag, ".valid"}, data_v_o, 0);
    chk({tag, ".data"},  data_o,   0);
    chk({tag, ".last"},  last_o,   0);
    chk({tag, ".busy"},  busy_o,   0);
  endtask

  // Called at a negedge with the DUT idle; pulses one digest.
  task automatic start(input logic [255:0] d);
    check_quiet("idle");
    exp_q.delete();
    add_digest(d);
    hash_v_i = 1'b1;
    hash_i   = d;
    @(negedge clk);
    hash_v_i = 1'b0;
    hash_i   = rnd256();
  endtask

  // Streams exp_q; optional drops (drop_a, drop_c with clr), a chained
  // digest on the first digest's final accept, or reset at beat rst_at.
  task automatic stream(input bit rnd, input int drop_a, input int drop_c,
                        input bit do_b2b, input logic [255:0] b2b, input int rst_at);
    int k = 0;
    int budget = 0;
    bit prev_stall = 1'b0;
    bit da = 1'b0, dc = 1'b0;
    logic [7:0] prev = '0;
    if (do_b2b) add_digest(b2b);
    while (k < exp_q.size()) begin
      if (budget++ > 1000) begin
        chk("timeout", 1, 0);
        break;
      end
      chk("valid", data_v_o, 1);
      chk("data",  data_o,   exp_q[k]);
      chk("last",  last_o,   (k % N) == N - 1);
      chk("busy",  busy_o,   1);
      chk("ovf",   ovf_o,    ovf_exp);
      if (prev_stall) chk("stable", data_o, prev);
      if (k == rst_at) begin
        nreset = 1'b0;
        #1;
        check_quiet("rst");
        chk("rst.ovf", ovf_o, 0);
        ovf_exp = 1'b0;
        return;
      end
      ready_i   = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      hash_v_i  = 1'b0;
      clr_ovf_i = 1'b0;
      hash_i    = rnd256();
      if (do_b2b && k == N - 1 && ready_i) begin
        hash_v_i = 1'b1;
        hash_i   = b2b;
      end
      if (drop_a >= 0 && !da && k >= drop_a) begin
        hash_v_i = 1'b1;
        da = 1'b1;
      end
      if (drop_c >= 0 && !dc && k >= drop_c) begin
        hash_v_i  = 1'b1;
        clr_ovf_i = 1'b1;
        dc = 1'b1;
      end
      // A pulse is chained only on a final-beat accept; otherwise it overflows.
      if (hash_v_i && !(ready_i && (k % N) == N - 1)) ovf_exp = 1'b1;
      else if (clr_ovf_i) ovf_exp = 1'b0;
      prev_stall = !ready_i;
      prev = data_o;
      if (ready_i) k++;
      @(negedge clk);
    end
    hash_v_i  = 1'b0;
    clr_ovf_i = 1'b0;
    check_quiet("end");
    chk("end.ovf", ovf_o, ovf_exp);
  endtask

  initial begin
    logic [255:0] d0, d1;
    for (int k = 0; k < N; k++) begin
      d0[255 - 8*k -: 8] = 8'(k);
      d1[255 - 8*k -: 8] = 8'(8'hFF - k);
    end

    // Reset state
    #12;
    check_quiet("reset");
    chk("reset.ovf", ovf_o, 0);
    @(negedge clk);
    nreset = 1'b1;
    @(negedge clk);

    // Basic stream, ready tied high
    start(d0);
    stream(1'b0, -1, -1, 1'b0, '0, -1);
    @(negedge clk);

    // Backpressure
    start(d0);
    stream(1'b1, -1, -1, 1'b0, '0, -1);
    @(negedge clk);

    // Overflow at beat 10, then a second drop with clear (set wins)
    start(d0);
    stream(1'b0, 10, 20, 1'b0, '0, -1);
    @(negedge clk);
    chk("ovf.held", ovf_o, 1);
    clr_ovf_i = 1'b1;
    @(negedge clk);
    clr_ovf_i = 1'b0;
    ovf_exp = 1'b0;
    chk("ovf.clr", ovf_o, 0);

    // Back-to-back on the final accept, fixed then random with backpressure
    start(d0);
    stream(1'b0, -1, -1, 1'b1, d1, -1);
    @(negedge clk);
    start(rnd256());
    stream(1'b1, 7, -1, 1'b1, rnd256(), -1);
    @(negedge clk);
    clr_ovf_i = 1'b1;
    @(negedge clk);
    clr_ovf_i = 1'b0;
    ovf_exp = 1'b0;

    // Reset mid-stream with overflow pending, then a fresh digest
    start(d0);
    stream(1'b0, 2, -1, 1'b0, '0, 5);
    @(negedge clk);
    nreset = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check_quiet("post_rst");
      chk("post_rst.ovf", ovf_o, 0);
    end
    start(rnd256());
    stream(1'b1, -1, -1, 1'b0, '0, -1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/blake2s_hash_ser.md
Name: blake2s_hash_ser

Overview:
- Downstream stage of blake2s_hash256.
- Captures the 256-bit digest when hash_v is pulsed, then streams it out one byte per accepted beat over an 8-bit valid/ready interface.
- Feeds the 8-bit dedicated output pins in top.
- Flags any digest that arrives while a previous one is still being streamed.

Parameters:
- HASH_W, 256, digest width in bits; must be a multiple of BYTE_W.
- BYTE_W, 8, output beat width in bits.

Ports:
- clk  input  1  system clock.
- nreset  input  1  asynchronous active-low reset.
- hash_v_i  input  1  single-cycle pulse: hash_i is valid this cycle.
- hash_i  input  HASH_W  digest from blake2s_hash256.
- ready_i  input  1  consumer accepts the current beat.
- clr_ovf_i  input  1  clears the sticky overflow flag.
- data_v_o  output  1  data_o holds a valid byte.
- data_o  output  BYTE_W  current output byte.
- last_o  output  1  the current beat is the final byte of the digest.
- busy_o  output  1  a digest is held and not yet fully sent.
- ovf_o  output  1  sticky flag: a digest was dropped.

Behaviour:
- Reset: one clock (clk); reset is asynchronous, active-low (nreset). While nreset is low:
  - state = IDLE, shift register = 0, beat counter = 0, ovf_o = 0;
  - data_v_o = 0, last_o = 0, busy_o = 0, data_o = 0.
- Reset mid-stream aborts the transfer immediately. No residue remains after reset is released.
- NBYTES = HASH_W/BYTE_W (32). Beat counter width = clog2(NBYTES) (5 bits).
- State IDLE:
  - data_v_o = 0, data_o forced to 0.
  - On hash_v_i: load hash_i into the shift register, counter = 0, go to SEND.
  - Latency is one cycle: data_v_o rises the cycle after hash_v_i.
- State SEND:
  - data_v_o = 1, busy_o = 1.
  - data_o = top BYTE_W bits of the shift register. The first byte sent is hash_i[255:248].
  - Beat accepted when data_v_o && ready_i. On accept: shift left by BYTE_W (zero fill), counter +1.
  - Without ready_i, data_o, last_o and the counter hold stable. Valid never drops before acceptance.
  - last_o = data_v_o && (counter == NBYTES-1).
  - Final beat accepted with no hash_v_i: go to IDLE.
- Simultaneous events:
  - hash_v_i in the same cycle the final beat is accepted: load the new digest, counter = 0, stay in SEND. The stream continues back-to-back with no bubble, and no overflow is flagged.
  - hash_v_i in SEND at any other time: the new digest is dropped, the current stream is unaffected, and ovf_o is set the next cycle.
  - ovf_o stays set until clr_ovf_i. If clr_ovf_i and a new overflow occur in the same cycle, set wins.
- busy_o is registered from state; it is high exactly while in SEND.
- hash_i is sampled only on the hash_v_i cycle. Its value on other cycles is ignored.

Optional Feature:
- Macro: BLAKE2S_SER_LSB_FIRST_EN.
- When defined:
  - the digest is emitted little-endian: first byte is hash_i[7:0];
  - the shift register shifts right and data_o takes the low byte.
- When undefined: MSB-first as described in Behaviour.
- All timing, last_o and overflow behaviour are identical in both builds.

Decomposition:
- Shared package holds the BLAKE2s constants: HASH_W (256), BYTE_W (8), NBYTES, and the counter width.
- The state enum {IDLE, SEND} is local to the block.
- No sub-module is needed; a single module with shift register, counter and two-state FSM is natural.

Test Plan:
- Basic stream: hash_i = 0x000102…1F, ready_i tied high, one hash_v_i pulse.
  - data_v_o high for exactly 32 cycles starting one cycle after the pulse.
  - data_o = 0x00, 0x01, … 0x1F in order.
  - last_o high only on 0x1F; busy_o falls after the last beat.
- Backpressure: same digest, ready_i toggling 1,0,0,1,… pseudo-randomly.
  - Byte sequence unchanged (0x00…0x1F), no duplicates or skips.
  - data_o stable whenever valid && !ready.
- Overflow: second hash_v_i at beat 10.
  - Stream continues 0x0A…0x1F unchanged; ovf_o = 1 the next cycle.
  - ovf_o held until a clr_ovf_i pulse, then 0.
- Back-to-back: second digest 0xFF…E0 pulsed on the final-beat accept cycle.
  - 64 consecutive valid beats: 0x00…0x1F then 0xFF…0xE0.
  - ovf_o stays 0.
- Reset mid-stream: nreset asserted at beat 5.
  - Outputs go to 0 asynchronously.
  - After release, idle until a new hash_v_i; the new digest starts at its first byte.
- With BLAKE2S_SER_LSB_FIRST_EN defined, same digest as the basic stream: data_o = 0x1F, 0x1E, … 0x00, with last_o on 0x00.
